// File: rtl/mp_addsub_serial.sv
// Limb-serial multi-precision add/sub engine with accumulate and single-cycle right shift.
// One LIMB-wide slice is summed per cycle; the carry is held in a register between limbs.
module mp_addsub_serial #(
    parameter int unsigned WIDTH = 514,
    parameter int unsigned LIMB  = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             shift,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH:0]   result,
    output logic             busy,
    output logic             done
);

    // ceil((WIDTH+1)/LIMB) limbs cover the WIDTH+1 bit result
    localparam int unsigned NLIMB = (WIDTH + LIMB) / LIMB;
    localparam int unsigned EXT   = NLIMB * LIMB;
    localparam int unsigned CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [EXT-1:0]  a_q, a_d;
    logic [EXT-1:0]  b_q, b_d;
    logic [EXT-1:0]  res_q, res_d;
    logic            carry_q, carry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic [LIMB:0]   sum;

    always_comb begin
        sum     = {1'b0, a_q[LIMB-1:0]} + {1'b0, b_q[LIMB-1:0]} + {{LIMB{1'b0}}, carry_q};
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // Subtraction is a + ~b + 1 over the full extended width
                    a_d     = mode[1] ? EXT'(res_q[WIDTH:0]) : EXT'(in_a);
                    b_d     = mode[0] ? ~EXT'(in_b) : EXT'(in_b);
                    carry_d = mode[0];
                    cnt_d   = '0;
                    state_d = StRun;
                end else if (shift) begin
                    res_d = EXT'(res_q[WIDTH:1]);
                end
            end
            StRun: begin
                res_d   = (res_q >> LIMB) | (EXT'(sum[LIMB-1:0]) << (EXT - LIMB));
                a_d     = a_q >> LIMB;
                b_d     = b_q >> LIMB;
                carry_d = sum[LIMB];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NLIMB - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign result = res_q[WIDTH:0];
    assign busy   = (state_q == StRun);
    assign done   = done_q;

endmodule

// File: tb/tb_mp_addsub_serial.sv
// Bench for mp_addsub_serial: three instances (LIMB 64, 1, 515) against an arithmetic model,
// plus literal expectations on directed vectors.
module tb_mp_addsub_serial;

    localparam int W  = 514;
    localparam int RW = 515;

    logic          clk = 1'b0;
    logic          resetn;
    logic [2:0]    start;
    logic [1:0]    mode;
    logic          shift;
    logic [W-1:0]  in_a, in_b;
    logic [RW-1:0] res0, res1, res2;
    logic [RW-1:0] dres [3];
    logic [2:0]    busy, done;

    int checks = 0;
    int errors = 0;
    bit checking = 0;

    always #5 clk = ~clk;

    mp_addsub_serial #(.WIDTH(W), .LIMB(64)) u_l64 (
        .clk(clk), .resetn(resetn), .start(start[0]), .mode(mode), .shift(shift),
        .in_a(in_a), .in_b(in_b), .result(res0), .busy(busy[0]), .done(done[0])
    );
    mp_addsub_serial #(.WIDTH(W), .LIMB(1)) u_l1 (
        .clk(clk), .resetn(resetn), .start(start[1]), .mode(mode), .shift(shift),
        .in_a(in_a), .in_b(in_b), .result(res1), .busy(busy[1]), .done(done[1])
    );
    mp_addsub_serial #(.WIDTH(W), .LIMB(515)) u_l515 (
        .clk(clk), .resetn(resetn), .start(start[2]), .mode(mode), .shift(shift),
        .in_a(in_a), .in_b(in_b), .result(res2), .busy(busy[2]), .done(done[2])
    );

    assign dres[0] = res0;
    assign dres[1] = res1;
    assign dres[2] = res2;

    function automatic int lat_of(int i);
        int l;
        l = (i == 0) ? 64 : (i == 1) ? 1 : 515;
        return (RW + l - 1) / l;
    endfunction

    function automatic logic [RW-1:0] op_of(logic [1:0] md, logic [W-1:0] a, logic [W-1:0] b,
                                            logic [RW-1:0] cur);
        logic [RW-1:0] x;
        x = md[1] ? cur : {1'b0, a};
        return md[0] ? (x - {1'b0, b}) : (x + {1'b0, b});
    endfunction

    // Model: result only changes on completion, shift, or reset
    logic [RW-1:0] m_res [3];
    logic [RW-1:0] m_pend [3];
    bit            m_busy [3];
    bit            m_done [3];
    int            m_cnt [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_res[i] = '0; m_pend[i] = '0; m_busy[i] = 0; m_done[i] = 0; m_cnt[i] = 0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!resetn) begin
                    m_res[i] = '0; m_busy[i] = 0; m_done[i] = 0; m_cnt[i] = 0;
                end else begin
                    m_done[i] = 0;
                    if (m_busy[i]) begin
                        m_cnt[i]++;
                        if (m_cnt[i] == lat_of(i)) begin
                            m_busy[i] = 0;
                            m_done[i] = 1;
                            m_res[i]  = m_pend[i];
                        end
                    end else if (start[i]) begin
                        m_pend[i] = op_of(mode, in_a, in_b, m_res[i]);
                        m_busy[i] = 1;
                        m_cnt[i]  = 0;
                    end else if (shift) begin
                        m_res[i] = m_res[i] >> 1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (busy[i] !== m_busy[i]) begin
                        errors++;
                        $display("FAIL busy[%0d] t=%0t got %b want %b", i, $time, busy[i], m_busy[i]);
                    end
                    checks++;
                    if (done[i] !== m_done[i]) begin
                        errors++;
                        $display("FAIL done[%0d] t=%0t got %b want %b", i, $time, done[i], m_done[i]);
                    end
                    if (!m_busy[i]) begin
                        checks++;
                        if (dres[i] !== m_res[i]) begin
                            errors++;
                            $display("FAIL result[%0d] t=%0t got %h want %h", i, $time,
                                     dres[i], m_res[i]);
                        end
                    end
                end
            end
        end
    end

    task automatic expect_lit(string name, int i, logic [RW-1:0] exp);
        checks++;
        if (dres[i] !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, dres[i], exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen
    task automatic run_op(int i, logic [1:0] md, logic [W-1:0] a, logic [W-1:0] b);
        int k;
        start[i] = 1'b1; mode = md; in_a = a; in_b = b;
        @(negedge clk);
        start[i] = 1'b0; mode = ~md; in_a = ~a; in_b = ~b;
        k = 0;
        while (!done[i] && k < 600) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!done[i]) begin
            errors++;
            $display("FAIL timeout[%0d] got done=0 want done=1", i);
        end
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    logic [W-1:0]  p01, p10, ones514;
    logic [RW-1:0] pow514;

    initial begin
        p01     = {257{2'b01}};
        p10     = {257{2'b10}};
        ones514 = {W{1'b1}};
        pow514  = {1'b1, {W{1'b0}}};
        resetn = 1'b0; start = '0; mode = '0; shift = 1'b0; in_a = '0; in_b = '0;
        idle(3);
        checking = 1;
        resetn = 1'b1;
        expect_lit("reset_result", 0, '0);
        checks++;
        if (busy !== 3'b000 || done !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got busy=%b done=%b want 000/000", busy, done);
        end
        idle(1);

        run_op(0, 2'b00, 1, 1);
        expect_lit("add_1_1", 0, 2);
        idle(2);
        run_op(0, 2'b00, p01, p10);
        expect_lit("add_pattern", 0, {1'b0, ones514});
        shift = 1'b1; @(negedge clk); shift = 1'b0;
        expect_lit("shift_once", 0, {2'b00, {(W-1){1'b1}}});
        idle(1);

        // Back-to-back: each start lands on the cycle done is high
        run_op(0, 2'b01, 1, 1);
        expect_lit("sub_1_1", 0, '0);
        run_op(0, 2'b01, 0, 1);
        expect_lit("sub_0_1", 0, {RW{1'b1}});
        run_op(0, 2'b01, p01, p10);
        expect_lit("sub_wrap", 0, {1'b1, {256{2'b10}}, 2'b11});
        run_op(0, 2'b00, ones514, 1);
        expect_lit("carry_ripple", 0, pow514);
        run_op(0, 2'b10, '0, 1);
        expect_lit("acc_add", 0, pow514 + 1);
        run_op(0, 2'b11, '1, 2);
        expect_lit("acc_sub", 0, {1'b0, ones514});
        idle(2);

        // start pulse mid-RUN must be ignored
        start[0] = 1'b1; mode = 2'b00; in_a = 5; in_b = 7;
        @(negedge clk); start[0] = 1'b0;
        idle(3);
        start[0] = 1'b1; mode = 2'b01; in_a = 100; in_b = 1;
        @(negedge clk); start[0] = 1'b0;
        idle(8);
        expect_lit("start_in_run", 0, 12);
        idle(2);

        // start and shift together: add wins
        shift = 1'b1;
        run_op(0, 2'b00, 3, 4);
        shift = 1'b0;
        expect_lit("start_beats_shift", 0, 7);
        idle(2);

        // Reset during the 4th RUN cycle
        start[0] = 1'b1; mode = 2'b00; in_a = 9; in_b = 9;
        @(negedge clk); start[0] = 1'b0;
        idle(3);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        expect_lit("reset_mid_run", 0, '0);
        idle(12);
        run_op(0, 2'b00, 20, 22);
        expect_lit("after_reset", 0, 42);
        idle(2);

        run_op(1, 2'b00, 1, 1);
        expect_lit("l1_add", 1, 2);
        run_op(1, 2'b01, 0, 1);
        expect_lit("l1_sub", 1, {RW{1'b1}});
        idle(2);
        run_op(2, 2'b00, 1, 1);
        expect_lit("l515_add", 2, 2);
        run_op(2, 2'b01, 0, 1);
        expect_lit("l515_sub", 2, {RW{1'b1}});
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
